// File: rtl/hps_avmm_pkg.sv
// Shared types and defaults for the HPS Avalon-MM request arbiter.
// Also provides the sizing helper for the read-timeout counter.
package hps_avmm_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RWAIT,
        ACK
    } state_t;

    // Counter must hold TIMEOUT-1; a one-cycle timeout still needs one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/hps_avmm_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Shared with other fabric arbiters, so it carries no Avalon knowledge.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    localparam int PW = IDX_W + 1;

    logic [PW-1:0] pos;
    logic          found;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = PW'(ptr) + PW'(k);
            if (pos >= PW'(N)) begin
                pos = pos - PW'(N);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
                grant = N'(1) << pos[IDX_W-1:0];
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/hps_avmm_arbiter.sv
// Round-robin sharing of the single f2h Avalon-MM master between fabric requesters.
// One transaction in flight; reads are bounded by a timeout so a stalled slave cannot hang a client.
module hps_avmm_arbiter
    import hps_avmm_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    input  logic [N_REQ*DATA_W/8-1:0] req_be,
    output logic [N_REQ-1:0]          req_ack,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         avm_address,
    output logic                      avm_read,
    output logic                      avm_write,
    output logic [DATA_W-1:0]         avm_writedata,
    output logic [DATA_W/8-1:0]       avm_byteenable,
    input  logic                      avm_waitrequest,
    input  logic [DATA_W-1:0]         avm_readdata,
    input  logic                      avm_readdatavalid
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [N_REQ-1:0]   owner_oh;
    logic               owner_write;
    logic [CNT_W-1:0]   cnt;
    logic               expired;

    logic [N_REQ-1:0]   win_grant;
    logic [IDX_W-1:0]   win_idx;
    logic               any_valid;

    logic [ADDR_W-1:0]  addr_arr  [N_REQ];
    logic [DATA_W-1:0]  wdata_arr [N_REQ];
    logic [BE_W-1:0]    be_arr    [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        assign be_arr[i]    = req_be[i*BE_W +: BE_W];
    end

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (win_grant),
        .idx       (win_idx),
        .any_valid (any_valid)
    );

    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response data wins over expiry when both land in the same RWAIT cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = CMD;
            CMD:     if (!avm_waitrequest) state_nxt = owner_write ? ACK : RWAIT;
            RWAIT:   if (avm_readdatavalid || expired) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ptr            <= '0;
            owner_oh       <= '0;
            owner_write    <= 1'b0;
            cnt            <= '0;
            req_ack        <= '0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner_oh       <= win_grant;
                        owner_write    <= req_write[win_idx];
                        avm_address    <= addr_arr[win_idx];
                        avm_writedata  <= wdata_arr[win_idx];
                        avm_byteenable <= be_arr[win_idx];
                        avm_read       <= ~req_write[win_idx];
                        avm_write      <= req_write[win_idx];
                        ptr            <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    end
                end
                CMD: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        cnt       <= '0;
                        if (owner_write) begin
                            req_ack <= owner_oh;
                            rsp_err <= 1'b0;
                        end
                    end
                end
                RWAIT: begin
                    if (avm_readdatavalid) begin
                        rsp_rdata <= avm_readdata;
                        rsp_err   <= 1'b0;
                        req_ack   <= owner_oh;
                    end else if (expired) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        req_ack   <= owner_oh;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    req_ack <= '0;
                end
                default: begin
                    req_ack <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hps_avmm_arbiter.sv
// Self-checking bench for hps_avmm_arbiter: Avalon slave model, transaction table and scoreboard.
// Expected command fields and completions are queued when requests are driven.
module tb_hps_avmm_arbiter;

    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;
    localparam int TIMEOUT = 16;

    logic                      clk_clk = 1'b0;
    logic                      reset_reset_n = 1'b0;
    logic [N_REQ-1:0]          req_valid = '0;
    logic [N_REQ-1:0]          req_write = '0;
    logic [N_REQ*ADDR_W-1:0]   req_addr = '0;
    logic [N_REQ*DATA_W-1:0]   req_wdata = '0;
    logic [N_REQ*BE_W-1:0]     req_be = '0;
    logic [N_REQ-1:0]          req_ack;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [ADDR_W-1:0]         avm_address;
    logic                      avm_read;
    logic                      avm_write;
    logic [DATA_W-1:0]         avm_writedata;
    logic [BE_W-1:0]           avm_byteenable;
    logic                      avm_waitrequest = 1'b0;
    logic [DATA_W-1:0]         avm_readdata = '0;
    logic                      avm_readdatavalid = 1'b0;

    hps_avmm_arbiter #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .req_valid         (req_valid),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_be            (req_be),
        .req_ack           (req_ack),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        int          owner;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          wait_cyc;
        int          rdv_dly;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_len;
        int          exp_lat;
        int          drive_cyc;
    } vec_t;

    vec_t        tbl [6];
    vec_t        cmd_q [$];
    vec_t        ack_q [$];
    vec_t        cur_cmd;
    vec_t        v;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          acks_seen = 0;
    int          cfg_wait = 0;
    int          cfg_rdv = 0;
    logic [31:0] cfg_rdata = '0;
    int          wcount = 0;
    int          rdv_pend = -1;
    logic [31:0] rdv_data = '0;
    logic        prev_vis = 1'b0;
    int          cmd_len = 0;
    logic [3:0]  keep_mask = '0;
    int          tgt;
    int          n;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic vis;
        vec_t e;
        vis = avm_read | avm_write;
        checkOutput("rd_wr_exclusive", 64'(avm_read & avm_write), 64'(0));
        if (vis && !prev_vis) begin
            if (cmd_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_cmd: got addr 0x%0h, expected no command", avm_address);
            end else begin
                cur_cmd = cmd_q.pop_front();
            end
            cmd_len = 0;
        end
        if (vis) begin
            cmd_len++;
            checkOutput("cmd_write", 64'(avm_write), 64'(cur_cmd.write));
            checkOutput("cmd_addr", 64'(avm_address), 64'(cur_cmd.addr));
            checkOutput("cmd_be", 64'(avm_byteenable), 64'(cur_cmd.be));
            if (cur_cmd.write) checkOutput("cmd_wdata", 64'(avm_writedata), 64'(cur_cmd.wdata));
        end
        if (!vis && prev_vis && cur_cmd.exp_len > 0) begin
            checkOutput("cmd_len", 64'(cmd_len), 64'(cur_cmd.exp_len));
        end
        prev_vis = vis;
        if (req_ack != '0) begin
            acks_seen++;
            if (ack_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_ack: got 0x%0h, expected 0x0", req_ack);
            end else begin
                e = ack_q.pop_front();
                checkOutput("ack_vec", 64'(req_ack), 64'(4'(1) << e.owner));
                checkOutput("rsp_err", 64'(rsp_err), 64'(e.exp_err));
                if (!e.write) checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.exp_rdata));
                if (e.exp_lat > 0) checkOutput("ack_latency", 64'(cyc - e.drive_cyc), 64'(e.exp_lat));
            end
            req_valid = req_valid & ~(req_ack & ~keep_mask);
        end
    endtask

    // Avalon slave: holds waitrequest for cfg_wait cycles, answers reads cfg_rdv cycles after acceptance.
    task automatic slave();
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom();
        if (rdv_pend > 0) begin
            rdv_pend--;
            if (rdv_pend == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = rdv_data;
                rdv_pend          = -1;
            end
        end
        if (avm_read || avm_write) begin
            if (wcount < cfg_wait) begin
                avm_waitrequest = 1'b1;
                wcount++;
            end else begin
                avm_waitrequest = 1'b0;
                wcount = 0;
                if (avm_read && cfg_rdv > 0) begin
                    rdv_pend = cfg_rdv;
                    rdv_data = cfg_rdata;
                end
            end
        end else begin
            avm_waitrequest = 1'b0;
            wcount = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
        cyc++;
        monitor();
        slave();
    endtask

    task automatic driveReq(input vec_t d);
        req_valid[d.owner] = 1'b1;
        req_write[d.owner] = d.write;
        req_addr[d.owner*ADDR_W +: ADDR_W] = d.addr;
        req_wdata[d.owner*DATA_W +: DATA_W] = d.wdata;
        req_be[d.owner*BE_W +: BE_W] = d.be;
    endtask

    task automatic applyStimulus(input vec_t d);
        tick();
        cfg_wait  = d.wait_cyc;
        cfg_rdv   = d.rdv_dly;
        cfg_rdata = d.rdata;
        d.drive_cyc = cyc;
        driveReq(d);
        cmd_q.push_back(d);
        ack_q.push_back(d);
    endtask

    task automatic waitAcks(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (acks_seen < target && k < budget) begin
            tick();
            k++;
        end
        checkOutput(name, 64'(acks_seen), 64'(target));
    endtask

    initial begin
        tbl[0] = '{owner:2, write:1'b1, addr:32'h0000_0100, wdata:32'hDEAD_BEEF, be:4'hF, wait_cyc:0, rdv_dly:0,
                   rdata:32'h0, exp_err:1'b0, exp_rdata:32'h0, exp_len:1, exp_lat:2, drive_cyc:0};
        tbl[1] = '{owner:1, write:1'b0, addr:32'h2000_0040, wdata:32'h0, be:4'hF, wait_cyc:5, rdv_dly:3,
                   rdata:32'h1234_5678, exp_err:1'b0, exp_rdata:32'h1234_5678, exp_len:6, exp_lat:10, drive_cyc:0};
        tbl[2] = '{owner:0, write:1'b0, addr:32'h0000_0080, wdata:32'h0, be:4'hF, wait_cyc:0, rdv_dly:16,
                   rdata:32'hCAFE_F00D, exp_err:1'b0, exp_rdata:32'hCAFE_F00D, exp_len:1, exp_lat:18, drive_cyc:0};
        tbl[3] = '{owner:3, write:1'b1, addr:32'h0000_0300, wdata:32'h0BAD_F00D, be:4'h6, wait_cyc:2, rdv_dly:0,
                   rdata:32'h0, exp_err:1'b0, exp_rdata:32'h0, exp_len:3, exp_lat:4, drive_cyc:0};
        tbl[4] = '{owner:1, write:1'b0, addr:32'h0000_0A00, wdata:32'h0, be:4'h3, wait_cyc:1, rdv_dly:15,
                   rdata:32'h55AA_33CC, exp_err:1'b0, exp_rdata:32'h55AA_33CC, exp_len:2, exp_lat:18, drive_cyc:0};
        tbl[5] = '{owner:2, write:1'b0, addr:32'h0000_1234, wdata:32'h0, be:4'hF, wait_cyc:0, rdv_dly:1,
                   rdata:32'h0F0F_0F0F, exp_err:1'b0, exp_rdata:32'h0F0F_0F0F, exp_len:1, exp_lat:3, drive_cyc:0};

        repeat (3) tick();
        checkOutput("rst_address", 64'(avm_address), 64'(0));
        checkOutput("rst_read", 64'(avm_read), 64'(0));
        checkOutput("rst_write", 64'(avm_write), 64'(0));
        checkOutput("rst_writedata", 64'(avm_writedata), 64'(0));
        checkOutput("rst_byteenable", 64'(avm_byteenable), 64'(0));
        checkOutput("rst_ack", 64'(req_ack), 64'(0));
        checkOutput("rst_rdata", 64'(rsp_rdata), 64'(0));
        checkOutput("rst_err", 64'(rsp_err), 64'(0));
        reset_reset_n = 1'b1;
        repeat (2) tick();

        // All four requesters write continuously from ptr=0: grants 0,1,2,3,0 every 3 cycles.
        tick();
        cfg_wait  = 0;
        keep_mask = 4'hF;
        tgt = acks_seen + 5;
        for (int i = 0; i < 5; i++) begin
            v = '{owner:i % 4, write:1'b1, addr:32'h0000_1000 + 32'((i % 4) * 16), wdata:32'hC0DE_0000 + 32'(i % 4),
                  be:4'(4'hF >> (3 - (i % 4))), wait_cyc:0, rdv_dly:0, rdata:32'h0, exp_err:1'b0, exp_rdata:32'h0,
                  exp_len:1, exp_lat:2 + 3 * i, drive_cyc:cyc};
            if (i < 4) driveReq(v);
            cmd_q.push_back(v);
            ack_q.push_back(v);
        end
        waitAcks(tgt, 40, "rr_burst_acks");
        req_valid = '0;
        keep_mask = '0;
        repeat (4) tick();

        for (int i = 0; i < 6; i++) begin
            tgt = acks_seen + 1;
            applyStimulus(tbl[i]);
            waitAcks(tgt, 60, $sformatf("vec%0d_acks", i));
            repeat (2) tick();
        end

        // Timeout, then a stale response while idle, then a fresh read.
        v = '{owner:3, write:1'b0, addr:32'h4000_0000, wdata:32'h0, be:4'hF, wait_cyc:0, rdv_dly:18,
              rdata:32'h7777_7777, exp_err:1'b1, exp_rdata:32'h0, exp_len:1, exp_lat:18, drive_cyc:0};
        tgt = acks_seen + 1;
        applyStimulus(v);
        waitAcks(tgt, 60, "timeout_acks");
        repeat (3) tick();
        checkOutput("stale_rdata_held", 64'(rsp_rdata), 64'(0));
        checkOutput("stale_err_held", 64'(rsp_err), 64'(1));
        v = '{owner:3, write:1'b0, addr:32'h4000_0004, wdata:32'h0, be:4'hF, wait_cyc:0, rdv_dly:2,
              rdata:32'h600D_DA7A, exp_err:1'b0, exp_rdata:32'h600D_DA7A, exp_len:1, exp_lat:4, drive_cyc:0};
        tgt = acks_seen + 1;
        applyStimulus(v);
        waitAcks(tgt, 60, "after_timeout_acks");
        repeat (2) tick();

        // Reset while a read from req 2 is stalled in CMD; ptr has already moved to 3.
        tick();
        cfg_wait = 1000;
        v = '{owner:2, write:1'b0, addr:32'h5000_0000, wdata:32'h0, be:4'hF, wait_cyc:1000, rdv_dly:0,
              rdata:32'h0, exp_err:1'b0, exp_rdata:32'h0, exp_len:0, exp_lat:0, drive_cyc:cyc};
        driveReq(v);
        cmd_q.push_back(v);
        n = 0;
        while (!avm_read && n < 5) begin
            tick();
            n++;
        end
        repeat (2) tick();
        checkOutput("abort_cmd_pending", 64'(avm_read), 64'(1));
        #2;
        reset_reset_n = 1'b0;
        req_valid = '0;
        #1;
        checkOutput("async_rst_read", 64'(avm_read), 64'(0));
        checkOutput("async_rst_write", 64'(avm_write), 64'(0));
        checkOutput("async_rst_ack", 64'(req_ack), 64'(0));
        checkOutput("async_rst_address", 64'(avm_address), 64'(0));
        repeat (2) tick();
        reset_reset_n = 1'b1;
        cfg_wait = 0;
        tick();
        tgt = acks_seen + 2;
        v = '{owner:0, write:1'b1, addr:32'h0000_0600, wdata:32'h1111_2222, be:4'hF, wait_cyc:0, rdv_dly:0,
              rdata:32'h0, exp_err:1'b0, exp_rdata:32'h0, exp_len:1, exp_lat:2, drive_cyc:cyc};
        driveReq(v);
        cmd_q.push_back(v);
        ack_q.push_back(v);
        v = '{owner:3, write:1'b1, addr:32'h0000_0700, wdata:32'h3333_4444, be:4'hC, wait_cyc:0, rdv_dly:0,
              rdata:32'h0, exp_err:1'b0, exp_rdata:32'h0, exp_len:1, exp_lat:5, drive_cyc:cyc};
        driveReq(v);
        cmd_q.push_back(v);
        ack_q.push_back(v);
        waitAcks(tgt, 40, "post_reset_acks");
        repeat (4) tick();

        checkOutput("scoreboard_empty", 64'(cmd_q.size() + ack_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hps_avmm_arbiter.md
Name: hps_avmm_arbiter

Overview:
Round-robin arbiter sharing the single FPGA-to-HPS Avalon-MM master port of the HPS system (f2h bridge into HPS SDRAM/peripheral space) between N_REQ fabric requesters, for example PMU sample writers and a config/status reader.
- Single outstanding transaction, no bursts.
- Handles waitrequest back-pressure and read-response latency.
- Includes a read timeout so a stalled fabric cannot hang a requester.
- Sits between the fabric client logic and the top-level Qsys system instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 32, Avalon byte address width
DATA_W, 32, data width (multiple of 8)
TIMEOUT, 1024, max cycles waiting for readdatavalid before error completion

Ports:
clk_clk  in  1  system clock; all logic on rising edge
reset_reset_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request; held high with fields stable until req_ack
req_write  in  N_REQ  1=write, 0=read
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data
req_be  in  N_REQ*DATA_W/8  packed byteenables
req_ack  out  N_REQ  one-cycle completion pulse to owner
rsp_rdata  out  DATA_W  read data, valid with req_ack
rsp_err  out  1  timeout flag, valid with req_ack
avm_address  out  ADDR_W  Avalon master address
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  DATA_W  Avalon write data
avm_byteenable  out  DATA_W/8  Avalon byteenable
avm_waitrequest  in  1  slave stall
avm_readdata  in  DATA_W  read data
avm_readdatavalid  in  1  read response strobe

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs 0, state IDLE, rr pointer 0, timeout counter 0.
  - Reset mid-transaction aborts silently; no ack is issued.
- All outputs are registered.
- States: IDLE, CMD, RWAIT, ACK.
- IDLE:
  - If any req_valid is set, pick the winner: the first set bit scanning from index ptr upward, wrapping.
  - Latch the owner and its addr/wdata/be/write; assert avm_read or avm_write on the next cycle; go to CMD.
  - Set ptr = owner+1 mod N_REQ.
- CMD:
  - Hold command and fields stable while avm_waitrequest=1. No timeout in CMD (Avalon forbids withdrawing a command).
  - On waitrequest=0: drop avm_read/avm_write.
  - Write: go to ACK.
  - Read: clear counter, go to RWAIT.
- RWAIT:
  - Count cycles.
  - On avm_readdatavalid: capture avm_readdata into rsp_rdata, rsp_err=0, go to ACK.
  - Readdatavalid takes priority over expiry in the same cycle.
  - When the counter reaches TIMEOUT-1 with no readdatavalid: rsp_rdata=0, rsp_err=1, go to ACK.
- ACK: req_ack[owner]=1 for exactly one cycle, then IDLE. rsp_rdata/rsp_err hold until the next ACK.
- Latency with zero waitrequest:
  - req_valid sampled at cycle t; avm command at t+1; write ack at t+2.
  - Read: readdatavalid at cycle r gives ack at r+1.
  - Minimum write issue interval is 3 cycles.
- readdatavalid outside RWAIT (stale response after timeout) is discarded.
- Fairness: a continuously requesting client waits at most N_REQ-1 transactions.
- Requester dropping req_valid before ack is a protocol violation. The transaction still completes and the ack is still pulsed.
- Counter width is clog2(TIMEOUT); TIMEOUT=1 means expiry on the first RWAIT cycle.

Decomposition:
- Package hps_avmm_pkg:
  - state enum (IDLE/CMD/RWAIT/ACK).
  - Default width constants.
  - Function for the clog2-based counter width.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: req vector, ptr. Outputs: one-hot grant, index, any_valid.
  - Reusable by other fabric arbiters.

Test Plan:
1. Single write from req 2: addr 0x0000_0100, wdata 0xDEADBEEF, be 0xF, waitrequest=0 -> avm_write high for exactly 1 cycle with those values; req_ack=4'b0100 two cycles after req_valid.
2. All 4 requesters write continuously (ptr=0) -> grant order 0,1,2,3,0; each ack one-hot; no requester granted twice before the others.
3. Read from req 1, waitrequest held 5 cycles, readdatavalid 3 cycles after acceptance with 0x1234_5678 -> avm_read and address stable 6 cycles; req_ack[1] the cycle after readdatavalid; rsp_rdata=0x12345678, rsp_err=0.
4. Read with TIMEOUT=16 and no readdatavalid -> req_ack pulse 16 cycles after acceptance with rsp_err=1, rsp_rdata=0. Then a late readdatavalid in IDLE is ignored, and the following read returns its own data.
5. Assert reset_reset_n=0 asynchronously during CMD with waitrequest=1 -> avm_read/avm_write/req_ack drop immediately; after release, state IDLE, ptr=0, and a new request from req 0 completes normally.
6. readdatavalid and timeout expiry in the same cycle -> rsp_err=0 and data returned.
